// File: rtl/sonar_range.sv
// Echo-count to centimetre converter: restoring divider, saturation, optional
// 4-sample moving average (define SONAR_RANGE_AVG_EN), proximity flag.
module sonar_range #(
  parameter int unsigned DIVISOR = 58
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idle,
  input  logic [15:0] count_echo,
  input  logic [7:0]  threshold,
  output logic [7:0]  dist_cm,
  output logic        dist_valid,
  output logic        near,
  output logic        busy,
  output logic        overrun
);

  localparam logic [16:0] DivisorW = 17'(DIVISOR);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_AVG, S_OUT} state_e;

  state_e      state_q, state_d;
  logic        idle_q;
  logic        edgeDet;
  logic [15:0] dividend_q;
  logic [15:0] quot_q;
  logic [16:0] rem_q;
  logic [3:0]  bitCnt_q;
  logic [16:0] remShift;
  logic        remGeq;
  logic [7:0]  sample;
  logic [7:0]  resultD;
  logic [7:0]  dist_q;
  logic        near_q;
  logic        valid_q;
  logic        overrun_q;

  assign edgeDet  = idle & ~idle_q;
  assign remShift = 17'({rem_q, dividend_q[15]});
  assign remGeq   = remShift >= DivisorW;
  assign sample   = (quot_q[15:8] != 8'd0) ? 8'hFF : quot_q[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (edgeDet) state_d = S_DIV;
      S_DIV:  if (bitCnt_q == 4'd15) state_d = S_AVG;
      S_AVG:  state_d = S_OUT;
      S_OUT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_DIV) || (state_q == S_AVG);
  end

  // Divider and output registers; idle_q resets high so a level already high is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q     <= 1'b1;
      dividend_q <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      bitCnt_q   <= '0;
      dist_q     <= '0;
      near_q     <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      idle_q    <= idle;
      valid_q   <= 1'b0;
      overrun_q <= edgeDet && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (edgeDet) begin
            dividend_q <= count_echo;
            quot_q     <= '0;
            rem_q      <= '0;
            bitCnt_q   <= '0;
          end
        end
        S_DIV: begin
          rem_q      <= remGeq ? (remShift - DivisorW) : remShift;
          quot_q     <= {quot_q[14:0], remGeq};
          dividend_q <= {dividend_q[14:0], 1'b0};
          bitCnt_q   <= bitCnt_q + 4'd1;
        end
        S_OUT: begin
          dist_q  <= resultD;
          near_q  <= resultD < threshold;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SONAR_RANGE_AVG_EN
  logic [7:0] hist_q [4];
  logic       primed_q;
  logic [9:0] histSum;

  // The first sample after reset fills every slot so the average starts at that sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      primed_q <= 1'b0;
    end else if (state_q == S_AVG) begin
      if (primed_q) begin
        hist_q[3] <= hist_q[2];
        hist_q[2] <= hist_q[1];
        hist_q[1] <= hist_q[0];
        hist_q[0] <= sample;
      end else begin
        for (int i = 0; i < 4; i++) hist_q[i] <= sample;
      end
      primed_q <= 1'b1;
    end
  end

  always_comb begin
    histSum = 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]) + 10'(hist_q[3]);
    resultD = 8'(histSum >> 2);
  end
`else
  always_comb begin
    resultD = sample;
  end
`endif

  assign dist_cm    = dist_q;
  assign near       = near_q;
  assign dist_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sonar_range.sv
// Directed self-checking bench for sonar_range (DIVISOR=58); expectations adapt
// to SONAR_RANGE_AVG_EN where averaging changes the result.
module tb_sonar_range;

  logic        clk = 1'b0;
  logic        rst;
  logic        idle;
  logic [15:0] count_echo;
  logic [7:0]  threshold;
  logic [7:0]  dist_cm;
  logic        dist_valid;
  logic        near;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sonar_range #(.DIVISOR(58)) dut (
    .clk        (clk),
    .rst        (rst),
    .idle       (idle),
    .count_echo (count_echo),
    .threshold  (threshold),
    .dist_cm    (dist_cm),
    .dist_valid (dist_valid),
    .near       (near),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Produces an idle 0->1 transition; returns at the negedge where idle rose.
  task automatic applyStimulus(input logic [15:0] cnt, input logic [7:0] thr);
    @(negedge clk);
    idle       = 1'b0;
    count_echo = cnt;
    threshold  = thr;
    @(negedge clk);
    idle = 1'b1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst  = 1'b1;
    idle = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic measure(input string tag, input bit withReset, input logic [15:0] cnt,
                         input logic [7:0] thr, input int expDist, input int expNear);
    int lat = 0;
    int busyCnt = 0;
    int ovr = 0;
    bit seen = 1'b0;
    if (withReset) doReset();
    applyStimulus(cnt, thr);
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      busyCnt += int'(busy);
      ovr += int'(overrun);
      if (dist_valid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    checkOutput({tag, ".latency"}, lat, 19);
    checkOutput({tag, ".busyCycles"}, busyCnt, 17);
    checkOutput({tag, ".overrun"}, ovr, 0);
    checkOutput({tag, ".dist"}, dist_cm, expDist);
    checkOutput({tag, ".near"}, near, expNear);
  endtask

  initial begin
    int validCnt;
    int ovrCnt;
    int validAt [2];
    logic [7:0] distSeen [2];
    logic nearSeen [2];

    rst        = 1'b1;
    idle       = 1'b1;
    count_echo = '0;
    threshold  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.dist", dist_cm, 0);
    checkOutput("reset.valid", dist_valid, 0);
    checkOutput("reset.near", near, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.overrun", overrun, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("postReset.noSpuriousBusy", busy, 0);
    checkOutput("postReset.noSpuriousValid", dist_valid, 0);

    measure("m580", 1'b1, 16'd580, 8'd0, 10, 0);
    measure("m65535", 1'b1, 16'd65535, 8'd0, 255, 0);
    measure("zeroEcho", 1'b1, 16'd0, 8'd20, 0, 1);
    measure("m1160", 1'b1, 16'd1160, 8'd20, 20, 0);
    repeat (5) @(negedge clk);
    checkOutput("hold.dist", dist_cm, 20);
    checkOutput("hold.near", near, 0);
    checkOutput("hold.valid", dist_valid, 0);
    measure("thr255.sat", 1'b1, 16'd65535, 8'd255, 255, 0);
    measure("thr255.low", 1'b1, 16'd580, 8'd255, 10, 1);
    measure("zeroEcho.thr0", 1'b1, 16'd0, 8'd0, 0, 0);

    // Averaging sequence without intermediate resets.
    measure("avg1", 1'b1, 16'd580, 8'd0, 10, 0);
    measure("avg2", 1'b0, 16'd580, 8'd0, 10, 0);
    measure("avg3", 1'b0, 16'd580, 8'd0, 10, 0);
    measure("avg4", 1'b0, 16'd580, 8'd0, 10, 0);
`ifdef SONAR_RANGE_AVG_EN
    measure("avg5", 1'b0, 16'd2900, 8'd0, 20, 0);
`else
    measure("avg5", 1'b0, 16'd2900, 8'd0, 50, 0);
`endif

    // Second edge mid-conversion is dropped with a single overrun pulse.
    doReset();
    applyStimulus(16'd580, 8'd0);
    validCnt = 0;
    ovrCnt   = 0;
    distSeen[0] = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      ovrCnt += int'(overrun);
      if (dist_valid) begin
        validCnt++;
        distSeen[0] = dist_cm;
      end
      if (i == 4) begin
        idle       = 1'b0;
        count_echo = 16'd2900;
      end
      if (i == 5) idle = 1'b1;
    end
    checkOutput("overrun.pulses", ovrCnt, 1);
    checkOutput("overrun.validCount", validCnt, 1);
    checkOutput("overrun.dist", distSeen[0], 10);

    // Edge arriving in the cycle right after S_OUT is accepted.
    doReset();
    applyStimulus(16'd580, 8'd0);
    validCnt = 0;
    ovrCnt   = 0;
    validAt[0] = 0;
    validAt[1] = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      ovrCnt += int'(overrun);
      if (dist_valid && validCnt < 2) begin
        validAt[validCnt]  = i;
        distSeen[validCnt] = dist_cm;
        nearSeen[validCnt] = near;
        validCnt++;
      end
      if (i == 18) begin
        idle       = 1'b0;
        count_echo = 16'd1160;
      end
      if (i == 19) begin
        idle      = 1'b1;
        threshold = 8'd30;
      end
    end
    checkOutput("b2b.validCount", validCnt, 2);
    checkOutput("b2b.overrun", ovrCnt, 0);
    checkOutput("b2b.firstAt", validAt[0], 19);
    checkOutput("b2b.firstDist", distSeen[0], 10);
    checkOutput("b2b.firstNear", nearSeen[0], 0);
    checkOutput("b2b.secondAt", validAt[1], 38);
`ifdef SONAR_RANGE_AVG_EN
    checkOutput("b2b.secondDist", distSeen[1], 12);
`else
    checkOutput("b2b.secondDist", distSeen[1], 20);
`endif
    checkOutput("b2b.secondNear", nearSeen[1], 1);

    // Reset mid-conversion aborts the measurement and clears outputs.
    measure("preAbort", 1'b1, 16'd1160, 8'd30, 20, 1);
    applyStimulus(16'd580, 8'd0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    validCnt = 0;
    ovrCnt   = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      validCnt += int'(dist_valid);
      ovrCnt += int'(overrun);
    end
    checkOutput("abort.validCount", validCnt, 0);
    checkOutput("abort.overrun", ovrCnt, 0);
    checkOutput("abort.dist", dist_cm, 0);
    checkOutput("abort.near", near, 0);
    checkOutput("abort.busy", busy, 0);
    measure("afterAbort", 1'b0, 16'd580, 8'd0, 10, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
